// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-port memory arbiter.
// State encoding, port identifiers and counter sizing.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LS = 1'b1;

    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin winner selection.
// A lone request always wins; on a tie the port not granted last wins.
module rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic req_0,
    input  logic req_1,
    input  logic last_gnt,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = req_0 | req_1;
        winner = PORT_IF;
        if (req_0 && req_1) begin
            winner = ~last_gnt;
        end else if (req_1) begin
            winner = PORT_LS;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (port 0) and load/store (port 1).
// One outstanding transaction; command latched until accepted; response timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_0,
    input  logic [AW-1:0] addr_0,
    input  logic [DW-1:0] wdata_0,
    input  logic          we_0,
    input  logic          req_1,
    input  logic [AW-1:0] addr_1,
    input  logic [DW-1:0] wdata_1,
    input  logic          we_1,
    output logic          gnt_0,
    output logic          gnt_1,
    output logic          done_0,
    output logic          done_1,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          sel,
    output logic          mem_valid,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic          mem_ready,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic          last_gnt;
    logic          pick_valid;
    logic          pick_win;
    logic [CW-1:0] cnt;
    logic          grant;
    logic          accept;
    logic          resp;
    logic          abort;

    rr_pick2 u_pick (
        .req_0    (req_0),
        .req_1    (req_1),
        .last_gnt (last_gnt),
        .valid    (pick_valid),
        .winner   (pick_win)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        accept    = 1'b0;
        resp      = 1'b0;
        abort     = 1'b0;
        mem_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_valid && !reset) begin
                    grant     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_valid = 1'b1;
                if (mem_ready) begin
                    accept    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    resp      = 1'b1;
                    state_nxt = IDLE;
                end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign gnt_0 = grant & (pick_win == PORT_IF);
    assign gnt_1 = grant & (pick_win == PORT_LS);

    // Command, owner and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt  <= PORT_LS;
            sel       <= PORT_IF;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            cnt       <= '0;
            rdata     <= '0;
            err       <= 1'b0;
            done_0    <= 1'b0;
            done_1    <= 1'b0;
        end else begin
            done_0 <= 1'b0;
            done_1 <= 1'b0;
            if (grant) begin
                sel       <= pick_win;
                last_gnt  <= pick_win;
                mem_addr  <= pick_win ? addr_1  : addr_0;
                mem_wdata <= pick_win ? wdata_1 : wdata_0;
                mem_we    <= pick_win ? we_1    : we_0;
            end
            if (accept) begin
                cnt <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + CW'(1);
            end
            if (resp || abort) begin
                rdata  <= resp ? mem_rdata : '0;
                err    <= abort;
                done_0 <= (sel == PORT_IF);
                done_1 <= (sel == PORT_LS);
            end
        end
    end

endmodule
